fact_table_writer: RTL and testbench

//  Upstream producer for the 256x64 factorial RAM. On a start pulse it computes 0!..n_max! iteratively.
//  It writes entry k! to RAM address k through the RAM's cen/wen/s_addr/s_din write port.

---
 rtl/fact_table_writer_if.sv | 27 ++
 rtl/fact_table_writer.sv | 116 +++++++++++
 tb/tb_fact_table_writer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fact_table_writer_if.sv
// Request/status and RAM write-port bundle for the factorial table writer.
// master: the requester that pulses start and observes status and the RAM port.
// slave:  the writer that drives the RAM write port.
interface fact_table_writer_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] n_max;
  logic              busy;
  logic              done;
  logic              ovf;
  logic              cen;
  logic              wen;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;

  modport master (
    output start, n_max,
    input  busy, done, ovf, cen, wen, s_addr, s_din
  );

  modport slave (
    input  start, n_max,
    output busy, done, ovf, cen, wen, s_addr, s_din
  );
endinterface

// File: rtl/fact_table_writer.sv
// Fills a factorial RAM with 0!..n_max! using a shift-add multiplier
// (one multiplier bit per cycle). Entries that do not fit in DATA_W
// saturate to all-ones, and every later entry of the run stays saturated.
module fact_table_writer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  fact_table_writer_if.slave  bus
);

  localparam int PROD_W = DATA_W + ADDR_W;
  localparam int BIT_W  = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, MUL, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] n_lat;
  logic [ADDR_W-1:0] k;
  logic [DATA_W-1:0] acc;
  logic [PROD_W-1:0] prod;
  logic [BIT_W-1:0]  bit_idx;

  logic [PROD_W-1:0] addend;
  logic [PROD_W-1:0] prod_next;
  logic              last_bit;
  logic              sat;

  // Next partial product and saturation decision for the current multiplier bit
  always_comb begin
    addend    = '0;
    if (k[bit_idx])
      addend = {{ADDR_W{1'b0}}, acc} << bit_idx;
    prod_next = prod + addend;
    last_bit  = (bit_idx == BIT_W'(ADDR_W - 1));
    sat       = bus.ovf || (prod_next[PROD_W-1:DATA_W] != '0);
  end

  // Controller FSM; the RAM port is registered and loaded on each entry into
  // WRITE, so it holds cen/wen/s_addr/s_din exactly for the WRITE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      n_lat      <= '0;
      k          <= '0;
      acc        <= DATA_W'(1);
      prod       <= '0;
      bit_idx    <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.cen    <= 1'b0;
      bus.wen    <= 1'b0;
      bus.s_addr <= '0;
      bus.s_din  <= '0;
    end else begin
      bus.done   <= 1'b0;
      bus.cen    <= 1'b0;
      bus.wen    <= 1'b0;
      bus.s_addr <= '0;
      bus.s_din  <= '0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_lat      <= bus.n_max;
            k          <= '0;
            acc        <= DATA_W'(1);
            bus.ovf    <= 1'b0;
            bus.busy   <= 1'b1;
            bus.cen    <= 1'b1;
            bus.wen    <= 1'b1;
            bus.s_addr <= '0;
            bus.s_din  <= DATA_W'(1);
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (k == n_lat) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            k       <= k + 1'b1;
            prod    <= '0;
            bit_idx <= '0;
            state   <= MUL;
          end
        end
        MUL: begin
          prod    <= prod_next;
          bit_idx <= bit_idx + 1'b1;
          if (last_bit) begin
            bus.cen    <= 1'b1;
            bus.wen    <= 1'b1;
            bus.s_addr <= k;
            if (sat) begin
              acc       <= '1;
              bus.ovf   <= 1'b1;
              bus.s_din <= '1;
            end else begin
              acc       <= prod_next[DATA_W-1:0];
              bus.s_din <= prod_next[DATA_W-1:0];
            end
            state <= WRITE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_table_writer.sv
// Bench for fact_table_writer with a behavioural 256x64 RAM on its write port.
module tb_fact_table_writer;

  localparam int DW = 64;
  localparam int AW = 8;
  localparam logic [63:0] SENT = 64'h8888888888888888;
  localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fact_table_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fact_table_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // RAM model: captures s_din at s_addr when cen and wen are high; also
  // accepts bench prefill writes while the writer is idle.
  logic [63:0] mem [256];
  logic        pf_en = 1'b0;
  logic [7:0]  pf_addr = '0;
  logic [63:0] pf_data = '0;
  int          wr_count = 0;

  always @(posedge clk) begin
    if (pf_en)
      mem[pf_addr] <= pf_data;
    else if (bus.cen && bus.wen) begin
      mem[bus.s_addr] <= bus.s_din;
      wr_count <= wr_count + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0]  n;
    logic [7:0]  addr;
    logic [63:0] data;
    logic        ovf;
    int          done_cyc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic prefill(input logic [7:0] a, input logic [63:0] d);
    pf_addr = a;
    pf_data = d;
    pf_en   = 1'b1;
    step();
    pf_en   = 1'b0;
  endtask

  // Pulse start for one edge; the period after the accepting edge is cycle 1.
  task automatic launch(input logic [7:0] n);
    bus.n_max = n;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.done) begin
        dc = cyc;
        return;
      end
      step();
    end
  endtask

  initial begin
    int dc;
    int w0;

    vecs[0]  = '{8'd5,   8'd0,   64'd1,                 1'b0, 47};
    vecs[1]  = '{8'd5,   8'd3,   64'd6,                 1'b0, 47};
    vecs[2]  = '{8'd5,   8'd5,   64'd120,               1'b0, 47};
    vecs[3]  = '{8'd20,  8'd10,  64'h0000000000375F00,  1'b0, 182};
    vecs[4]  = '{8'd20,  8'd20,  64'h21C3677C82B40000,  1'b0, 182};
    vecs[5]  = '{8'd22,  8'd20,  64'h21C3677C82B40000,  1'b1, 200};
    vecs[6]  = '{8'd22,  8'd21,  ONES,                  1'b1, 200};
    vecs[7]  = '{8'd22,  8'd22,  ONES,                  1'b1, 200};
    vecs[8]  = '{8'd3,   8'd3,   64'd6,                 1'b0, 29};
    vecs[9]  = '{8'd12,  8'd12,  64'h000000001C8CFC00,  1'b0, 110};
    vecs[10] = '{8'd255, 8'd255, ONES,                  1'b1, 2297};
    vecs[11] = '{8'd1,   8'd1,   64'd1,                 1'b0, 11};

    bus.start = 1'b0;
    bus.n_max = '0;

    // Reset state
    #7;
    chk("rst_ctrl", 64'({bus.busy, bus.done, bus.ovf, bus.cen, bus.wen, bus.s_addr}), 64'd0);
    chk("rst_din", bus.s_din, 64'd0);
    #4 rst_n = 1'b1;
    step();
    step();

    // Table-driven runs
    foreach (vecs[i]) begin
      prefill(vecs[i].addr, SENT);
      launch(vecs[i].n);
      chk($sformatf("v%0d_busy_c1", i), 64'(bus.busy), 64'd1);
      chk($sformatf("v%0d_ovf_clr", i), 64'(bus.ovf), 64'd0);
      wait_done(vecs[i].done_cyc + 20, dc);
      chk($sformatf("v%0d_done_cyc", i), 64'(dc), 64'(vecs[i].done_cyc));
      chk($sformatf("v%0d_ovf", i), 64'(bus.ovf), 64'(vecs[i].ovf));
      step();
      chk($sformatf("v%0d_busy_low", i), 64'(bus.busy), 64'd0);
      chk($sformatf("v%0d_ovf_hold", i), 64'(bus.ovf), 64'(vecs[i].ovf));
      chk($sformatf("v%0d_data", i), mem[vecs[i].addr], vecs[i].data);
    end

    // n_max=0: one write pulse in cycle 1, done in cycle 2, addr1 untouched
    prefill(8'd1, SENT);
    prefill(8'd0, SENT);
    w0 = wr_count;
    launch(8'd0);
    chk("z_port", 64'({bus.cen, bus.wen, bus.s_addr}), 64'({2'b11, 8'h00}));
    chk("z_din", bus.s_din, 64'd1);
    step();
    chk("z_done_c2", 64'({bus.done, bus.cen}), 64'b10);
    step();
    chk("z_wr_count", 64'(wr_count - w0), 64'd1);
    chk("z_addr0", mem[0], 64'd1);
    chk("z_addr1", mem[1], SENT);

    // start re-pulsed mid-run and in the DONE cycle: both ignored
    prefill(8'd6, SENT);
    prefill(8'd5, SENT);
    launch(8'd5);
    dc = -1;
    for (int i = 0; i < 60; i++) begin
      if (bus.done && dc < 0) dc = cyc;
      if (cyc == 48 || cyc == 49) begin
        chk($sformatf("r_busy_c%0d", cyc), 64'(bus.busy), 64'd0);
        chk($sformatf("r_cen_c%0d", cyc), 64'(bus.cen), 64'd0);
      end
      bus.n_max = 8'd9;
      bus.start = (cyc == 5 || cyc == 6 || (dc > 0 && cyc == dc));
      step();
    end
    bus.start = 1'b0;
    chk("r_done_cyc", 64'(dc), 64'd47);
    chk("r_addr5", mem[5], 64'd120);
    chk("r_addr6", mem[6], SENT);

    // Asynchronous reset in the middle of the k=3 multiply
    launch(8'd5);
    while (cyc < 23) step();
    chk("ar_busy_pre", 64'(bus.busy), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_ctrl", 64'({bus.busy, bus.done, bus.ovf, bus.cen, bus.wen, bus.s_addr}), 64'd0);
    chk("ar_din", bus.s_din, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    prefill(8'd3, SENT);
    launch(8'd3);
    wait_done(60, dc);
    chk("ar_done_cyc", 64'(dc), 64'd29);
    step();
    chk("ar_addr3", mem[3], 64'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
